// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM channel multiplexer.
package tdm_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } tdm_state_e;

    typedef struct packed {
        logic              found;
        logic [ADDR_W-1:0] idx;
    } slot_sel_t;

    // Lowest set bit of mask at or above index 'from'; from == NUM_CH yields found=0.
    function automatic slot_sel_t next_enabled(input logic [NUM_CH-1:0] mask,
                                               input logic [ADDR_W:0]   from);
        slot_sel_t         r;
        logic [ADDR_W-1:0] bit_idx;
        r = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            bit_idx = ADDR_W'(NUM_CH - 1 - k);
            if (mask[bit_idx] && ({1'b0, bit_idx} >= from)) begin
                r.found = 1'b1;
                r.idx   = bit_idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_next_slot.sv
// Combinational priority finder: next enabled channel at or above a start index.
module tdm_next_slot
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [ADDR_W:0]   from,
    output logic              found,
    output logic [ADDR_W-1:0] idx
);

    slot_sel_t sel;

    always_comb begin
        sel   = next_enabled(mask, from);
        found = sel.found;
        idx   = sel.idx;
    end

endmodule

// File: rtl/tdm_channel_mux.sv
// Round-robin TDM scanner of 8 channels onto d with slot address {a0,a1,a2}.
// Optional TDM_CHANNEL_MUX_SNAPSHOT_EN: capture ch_in at frame start and transmit that snapshot.
module tdm_channel_mux
    import tdm_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned IFG   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_in,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              d,
    output logic              a0,
    output logic              a1,
    output logic              a2,
    output logic              strobe,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned CNT_W      = 8;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG - 1);

    tdm_state_e        state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic              d_d, strobe_d, fs_d, busy_d;
    logic              start_frame;
    logic [NUM_CH-1:0] src;

    logic              first_found, next_found;
    logic [ADDR_W-1:0] first_idx, next_idx;

    tdm_next_slot u_first (
        .mask  (ch_mask),
        .from  ('0),
        .found (first_found),
        .idx   (first_idx)
    );

    tdm_next_slot u_next (
        .mask  (mask_q),
        .from  ({1'b0, idx_q} + 1'b1),
        .found (next_found),
        .idx   (next_idx)
    );

`ifdef TDM_CHANNEL_MUX_SNAPSHOT_EN
    logic [NUM_CH-1:0] snap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (start_frame) begin
            snap_q <= ch_in;
        end
    end

    assign src = snap_q;
`else
    assign src = ch_in;
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        addr_d      = {a0, a1, a2};
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && first_found) begin
                    start_frame = 1'b1;
                end
            end
            SETUP: begin
                state_d = DRIVE;
                cnt_d   = '0;
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (next_found) begin
                        state_d = SETUP;
                        idx_d   = next_idx;
                        addr_d  = next_idx;
                    end else if (IFG == 0) begin
                        // No gap: restart directly, as GAP's exit would.
                        if (first_found) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == IFG_LAST) begin
                    if (en && first_found) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d = SETUP;
            mask_d  = ch_mask;
            idx_d   = first_idx;
            addr_d  = first_idx;
        end

        fs_d     = start_frame;
        strobe_d = (state_d == DRIVE);
        d_d      = strobe_d & src[idx_d];
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            {a0, a1, a2} <= '0;
            d            <= 1'b0;
            strobe       <= 1'b0;
            frame_start  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            {a0, a1, a2} <= addr_d;
            d            <= d_d;
            strobe       <= strobe_d;
            frame_start  <= fs_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_tdm_channel_mux.sv
// Directed bench for tdm_channel_mux: DWELL=4/IFG=2 and DWELL=1/IFG=2 instances.
module tb_tdm_channel_mux;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [7:0] ch_in, ch_mask;

    logic d_a, a0_a, a1_a, a2_a, strobe_a, fs_a, busy_a;
    logic d_b, a0_b, a1_b, a2_b, strobe_b, fs_b, busy_b;

    tdm_channel_mux #(.DWELL(4), .IFG(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch_in), .ch_mask(ch_mask),
        .d(d_a), .a0(a0_a), .a1(a1_a), .a2(a2_a),
        .strobe(strobe_a), .frame_start(fs_a), .busy(busy_a)
    );

    tdm_channel_mux #(.DWELL(1), .IFG(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_in(ch_in), .ch_mask(ch_mask),
        .d(d_b), .a0(a0_b), .a1(a1_b), .a2(a2_b),
        .strobe(strobe_b), .frame_start(fs_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Observation word: {frame_start, busy, strobe, d, addr[2:0]}
    logic [6:0] obs_a, obs_b;
    assign obs_a = {fs_a, busy_a, strobe_a, d_a, a0_a, a1_a, a2_a};
    assign obs_b = {fs_b, busy_b, strobe_b, d_b, a0_b, a1_b, a2_b};

`ifdef TDM_CHANNEL_MUX_SNAPSHOT_EN
    localparam logic SNAP_EXP = 1'b0;
`else
    localparam logic SNAP_EXP = 1'b1;
`endif

    typedef struct {
        logic        sel;     // 0: dut_a (DWELL=4), 1: dut_b (DWELL=1)
        logic [7:0]  mask;
        logic [7:0]  ch;
        int          nslots;
        logic [23:0] slots;   // visit v slot index at [3v +: 3]
        logic [7:0]  dbits;   // visit v expected d at bit v
        int          len;     // hand-computed frame length
    } frame_vec_t;

    frame_vec_t vecs[6];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input logic sel, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if ((sel ? fs_b : fs_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_fs_wait"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy_a === 1'b0 && busy_b === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle_wait"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        frame_vec_t v;
        int         per, s, p, strobes;
        logic [2:0] slot, slot0, last;
        logic [6:0] exp, act;

        vecs[0] = '{1'b0, 8'hFF, 8'hA5, 8,
                    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8'b1010_0101, 42};
        vecs[1] = '{1'b0, 8'b0010_1100, 8'h0F, 3, {15'b0, 3'd5, 3'd3, 3'd2}, 8'b0000_0011, 17};
        vecs[2] = '{1'b0, 8'h80, 8'h80, 1, {21'b0, 3'd7}, 8'b0000_0001, 7};
        vecs[3] = '{1'b0, 8'h01, 8'hFE, 1, {21'b0, 3'd0}, 8'b0000_0000, 7};
        vecs[4] = '{1'b1, 8'b1000_0010, 8'h82, 2, {18'b0, 3'd7, 3'd1}, 8'b0000_0011, 6};
        vecs[5] = '{1'b0, 8'b0101_0000, 8'hBF, 2, {18'b0, 3'd6, 3'd4}, 8'b0000_0001, 12};

        rst_n = 1'b0; en = 1'b0; ch_in = '0; ch_mask = '0;
        #12;
        check("reset_a", {25'b0, obs_a}, 32'd0);
        check("reset_b", {25'b0, obs_b}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_a", {25'b0, obs_a}, 32'd0);
        check("post_reset_b", {25'b0, obs_b}, 32'd0);

        // en with an empty mask must not start a frame
        en = 1'b1;
        repeat (3) tick();
        check("empty_mask_a", {25'b0, obs_a}, 32'd0);
        check("empty_mask_b", {25'b0, obs_b}, 32'd0);
        en = 1'b0;

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            per   = (v.sel ? 1 : 4) + 1;
            slot0 = v.slots[2:0];
            last  = v.slots[3*(v.nslots-1) +: 3];
            ch_in = v.ch; ch_mask = v.mask; en = 1'b1;
            wait_fs(v.sel, $sformatf("vec%0d", i));
            for (int k = 0; k <= v.len; k++) begin
                if (k > 0) tick();
                s = k / per;
                p = k % per;
                if (k == v.len) begin
                    exp = {1'b1, 1'b1, 1'b0, 1'b0, slot0};
                end else if (s < v.nslots) begin
                    slot = v.slots[3*s +: 3];
                    if (p == 0) exp = {(s == 0), 1'b1, 1'b0, 1'b0, slot};
                    else        exp = {1'b0, 1'b1, 1'b1, v.dbits[s], slot};
                end else begin
                    exp = {1'b0, 1'b1, 1'b0, 1'b0, last};
                end
                act = v.sel ? obs_b : obs_a;
                check($sformatf("vec%0d_k%0d", i, k), {25'b0, act}, {25'b0, exp});
            end
            en = 1'b0;
            wait_idle($sformatf("vec%0d", i));
        end

        // en falls in the 2nd DRIVE cycle of slot 3
        ch_in = 8'h08; ch_mask = 8'hFF; en = 1'b1;
        wait_fs(1'b0, "endrop");
        repeat (15) tick();
        check("endrop_setup3", {25'b0, obs_a}, {25'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3});
        strobes = 0;
        for (int k = 16; k <= 19; k++) begin
            tick();
            if (k == 17) en = 1'b0;
            strobes += int'(strobe_a);
            check($sformatf("endrop_k%0d", k), {25'b0, obs_a},
                  {25'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3});
        end
        tick();
        check("endrop_idle", {25'b0, obs_a}, {25'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3});
        for (int k = 0; k < 10; k++) begin
            tick();
            strobes += int'(strobe_a) + int'(busy_a);
        end
        check("endrop_strobe_count", strobes, 32'd4);
        wait_idle("endrop");

        // async reset between edges during DRIVE of slot 2
        ch_in = 8'h04; ch_mask = 8'h04; en = 1'b1;
        wait_fs(1'b0, "arst");
        tick();
        check("arst_drive", {25'b0, obs_a}, {25'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2});
        #3 rst_n = 1'b0; en = 1'b0;
        #1 check("arst_immediate", {25'b0, obs_a}, 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("arst_hold%0d", k), {25'b0, obs_a}, 32'd0);
        end
        en = 1'b1;
        wait_fs(1'b0, "arst_restart");
        check("arst_restart_addr", {25'b0, obs_a}, {25'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2});
        en = 1'b0;
        wait_idle("arst");

        // ch_in[5] and ch_mask change mid-frame, before slot 5
        ch_in = 8'h00; ch_mask = 8'hFF; en = 1'b1;
        wait_fs(1'b0, "snap");
        repeat (10) tick();
        ch_in = 8'h20; ch_mask = 8'h01;
        repeat (15) tick();
        check("snap_setup5", {25'b0, obs_a}, {25'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5});
        for (int k = 26; k <= 29; k++) begin
            tick();
            check($sformatf("snap_k%0d", k), {25'b0, obs_a},
                  {25'b0, 1'b0, 1'b1, 1'b1, SNAP_EXP, 3'd5});
        end
        en = 1'b0;
        wait_idle("snap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_channel_mux.md
Name: tdm_channel_mux

Overview:
- Time-division multiplexer that scans 8 single-bit channel inputs onto one data line, d, plus a 3-bit slot address, a0/a1/a2.
- Drives the serial link that the robot's 1-to-8 demultiplexer decodes back into 8 outputs.
- Cycles round-robin through the enabled channels, spending a programmable dwell time in each slot.
- Inserts a guard cycle between slots, with d forced low, so the far-end decoder never glitches a wrong output during an address change.

Parameters:
- DWELL, 4: cycles per slot with strobe=1. Legal range 1..255.
- IFG, 2: idle cycles between frames. Legal range 0..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable, level-sensitive
- ch_in  in  8  channel data; ch_in[n] is carried in slot n
- ch_mask  in  8  1 = channel n is scanned; latched at each frame start
- d  out  1  serial data toward the demultiplexer
- a0  out  1  slot address, MSB (slot n = {a0,a1,a2})
- a1  out  1  slot address, middle bit
- a2  out  1  slot address, LSB
- strobe  out  1  high while d carries valid slot data
- frame_start  out  1  one-cycle pulse in the SETUP cycle of the first slot of a frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n low clears everything immediately, regardless of clock.
  - State goes to IDLE.
  - d, a0, a1, a2, strobe, frame_start and busy all go to 0.
  - Mask latch, slot index and both counters clear to 0.
- All outputs are registered.
- States: IDLE, SETUP, DRIVE, GAP.
- IDLE:
  - d=0, strobe=0; address holds its last value (0 after reset).
  - If en=1 and ch_mask!=0 at an edge: latch ch_mask, select the lowest enabled index, go to SETUP, and assert frame_start for that SETUP cycle.
  - If en=1 and ch_mask==0: stay in IDLE.
- SETUP (exactly 1 cycle):
  - Address is driven to the selected index, d=0, strobe=0.
  - Next state is DRIVE.
- DRIVE (DWELL cycles):
  - strobe=1, address held.
  - d = ch_in[index] as sampled at the previous rising edge (1-cycle latency).
  - After DWELL cycles, the next index is the next higher enabled bit of the latched mask.
    - If one exists and en=1: go to SETUP.
    - If none exists (frame complete): go to GAP.
    - If en=0: go to IDLE.
- GAP (IFG cycles):
  - d=0, strobe=0, address held.
  - At the end, if en=1 and ch_mask!=0: latch a new mask and start the next frame as from IDLE (SETUP with frame_start).
  - Otherwise go to IDLE.
  - IFG=0 means the last DRIVE cycle is followed directly by the next SETUP.
- Disabled channels are skipped in zero cycles.
- Frame length = (number of enabled channels)*(DWELL+1) + IFG cycles.
- en falling mid-frame: the current slot completes its full DWELL, then the block goes to IDLE with no GAP. en falling during SETUP: the DRIVE slot still completes. en falling during GAP: go to IDLE when GAP ends.
- ch_mask changes mid-frame are ignored until the next frame start.
- Wrap-around: index 7 is followed by the frame end; the block never wraps inside a frame.
- d is never 1 while strobe=0.

Optional Feature:
- Macro: TDM_CHANNEL_MUX_SNAPSHOT_EN.
- Defined: all 8 bits of ch_in are captured into a snapshot register on the same edge that latches ch_mask. Every slot of that frame transmits the snapshot bit, so a frame is a coherent sample.
- Undefined: d tracks ch_in live with the 1-cycle latency above, and no snapshot register exists.

Decomposition:
- Shared package tdm_pkg holds:
  - the state enum (IDLE, SETUP, DRIVE, GAP);
  - constants NUM_CH=8 and ADDR_W=3;
  - a function that returns the next enabled index above a given index from an 8-bit mask, plus a found flag.
- One natural sub-module, tdm_next_slot: the combinational priority finder for the next enabled channel, used both for the first-index and the next-index lookups.

Test Plan:
- Reset, en=0: all outputs 0; after release they stay 0 and busy=0.
- en=1, mask=8'hFF, DWELL=4, IFG=2, ch_in=8'hA5: address steps 0..7; d per slot = 1,0,1,0,0,1,0,1; frame length 42 cycles; frame_start once every 42 cycles.
- mask=8'b1000_0010, DWELL=1: slots 1 then 7 only; frame = 4+IFG cycles; d=0 and strobe=0 in both SETUP cycles.
- Drop en in the 2nd DRIVE cycle of slot 3: slot 3 completes 4 strobe cycles, then IDLE, busy=0, no further slots.
- Assert rst_n=0 between clock edges mid-DRIVE: d, strobe and address go to 0 without waiting for an edge; on release the block stays IDLE until en.
- SNAPSHOT_EN defined: toggle ch_in[5] mid-frame before slot 5 → slot 5 carries the value captured at frame start. SNAPSHOT_EN undefined: slot 5 carries the new value.
